// File: rtl/i2s_cfg_sequencer_if.sv
// Signal bundle between the host-side configuration logic and the I2S control sequencer.
interface i2s_cfg_sequencer_if;
    logic        cfg_req;
    logic [31:0] cfg_word;
    logic [1:0]  cfg_drain;
    logic        tx_empty;
    logic        rx_empty;
    logic        frame_end;
    logic        cfg_busy;
    logic        cfg_ack;
    logic        cfg_err;
    logic        tx_block;
    logic        stop;
    logic        ctrl_wen;
    logic [31:0] ctrl_wdata;

    modport master (
        output cfg_req, cfg_word, cfg_drain, tx_empty, rx_empty, frame_end,
        input  cfg_busy, cfg_ack, cfg_err, tx_block, stop, ctrl_wen, ctrl_wdata
    );

    modport slave (
        input  cfg_req, cfg_word, cfg_drain, tx_empty, rx_empty, frame_end,
        output cfg_busy, cfg_ack, cfg_err, tx_block, stop, ctrl_wen, ctrl_wdata
    );
endinterface

// File: rtl/i2s_cfg_sequencer.sv
// Applies a new I2S control word at a frame boundary: optional FIFO drain, frame sync,
// control write inside a held stop window, and a clean abort on timeout.
module i2s_cfg_sequencer #(
    parameter int TIMEOUT    = 1024,
    parameter int SETTLE_CYC = 4
) (
    input  logic               pclk,
    input  logic               preset,
    i2s_cfg_sequencer_if.slave cfg
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        SYNC   = 3'd2,
        WRITE  = 3'd3,
        SETTLE = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   word_q;
    logic [1:0]    drain_q;
    logic [TW-1:0] to_cnt;
    logic [SW-1:0] settle_cnt;
    logic          drain_ok;
    logic          timed_out;
    logic          accept;
    logic          busy_now;
    logic          busy_next;

    always_ff @(posedge pclk) begin
        if (!preset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The registered ack/err pulse is still visible in the IDLE cycle after DONE/ERR,
    // so a held request is only taken once that pulse has cleared.
    always_comb begin
        state_next = state;
        drain_ok   = (!drain_q[0] || cfg.tx_empty) && (!drain_q[1] || cfg.rx_empty);
        timed_out  = (to_cnt >= TIMEOUT_LAST);
        accept     = cfg.cfg_req && !cfg.cfg_ack && !cfg.cfg_err;
        case (state)
            IDLE:    if (accept) state_next = DRAIN;
            DRAIN: begin
                if (drain_ok) begin
                    state_next = SYNC;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            SYNC: begin
                if (cfg.frame_end) begin
                    state_next = WRITE;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            WRITE:   state_next = SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_now  = state inside {DRAIN, SYNC, WRITE, SETTLE};
        busy_next = state_next inside {DRAIN, SYNC, WRITE, SETTLE};
    end

    always_ff @(posedge pclk) begin
        if (!preset) begin
            word_q     <= '0;
            drain_q    <= '0;
            to_cnt     <= '0;
            settle_cnt <= '0;
        end else begin
            if (state == IDLE && state_next == DRAIN) begin
                word_q  <= cfg.cfg_word;
                drain_q <= cfg.cfg_drain;
            end
            if (state == IDLE) begin
                to_cnt <= '0;
            end else if ((state == DRAIN || state == SYNC) && to_cnt < TIMEOUT_MAX) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SW'(1);
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    // Busy covers both the current and the upcoming state so it rises on the accepting
    // edge and stays high until the DONE/ERR pulse, spanning the whole stop window.
    always_ff @(posedge pclk) begin
        if (!preset) begin
            cfg.cfg_busy   <= 1'b0;
            cfg.tx_block   <= 1'b0;
            cfg.stop       <= 1'b0;
            cfg.ctrl_wen   <= 1'b0;
            cfg.ctrl_wdata <= '0;
            cfg.cfg_ack    <= 1'b0;
            cfg.cfg_err    <= 1'b0;
        end else begin
            cfg.cfg_busy <= busy_now || busy_next;
            cfg.tx_block <= busy_now || busy_next;
            cfg.stop     <= (state == WRITE) || (state == SETTLE);
            cfg.ctrl_wen <= (state == WRITE);
            if (state == WRITE) begin
                cfg.ctrl_wdata <= word_q;
            end
            cfg.cfg_ack <= (state == DONE);
            cfg.cfg_err <= (state == ERR);
        end
    end

    a_ack_err_exclusive: assert property (@(posedge pclk) disable iff (!preset)
        !(cfg.cfg_ack && cfg.cfg_err));
    a_wen_ack_exclusive: assert property (@(posedge pclk) disable iff (!preset)
        !(cfg.ctrl_wen && cfg.cfg_ack));
    a_stop_within_busy: assert property (@(posedge pclk) disable iff (!preset)
        cfg.stop |-> cfg.cfg_busy);

endmodule

// File: tb/tb_i2s_cfg_sequencer.sv
// Directed bench: one DUT with the default timeout, one with TIMEOUT=16 for abort and race cases.
module tb_i2s_cfg_sequencer;

    logic pclk = 1'b0;
    logic preset = 1'b0;
    always #5 pclk = ~pclk;

    i2s_cfg_sequencer_if ifa ();
    i2s_cfg_sequencer_if ift ();

    i2s_cfg_sequencer #(.TIMEOUT(1024), .SETTLE_CYC(4)) dut_a (.pclk(pclk), .preset(preset), .cfg(ifa));
    i2s_cfg_sequencer #(.TIMEOUT(16), .SETTLE_CYC(4)) dut_t (.pclk(pclk), .preset(preset), .cfg(ift));

    logic        sel;
    logic        req;
    logic [31:0] word;
    logic [1:0]  drain;
    logic        txe;
    logic        rxe;
    logic        fe;

    // sel picks which DUT receives the stimulus; the other sits idle with empty FIFOs.
    assign ifa.cfg_req   = sel ? 1'b0 : req;
    assign ifa.cfg_word  = word;
    assign ifa.cfg_drain = drain;
    assign ifa.tx_empty  = sel ? 1'b1 : txe;
    assign ifa.rx_empty  = sel ? 1'b1 : rxe;
    assign ifa.frame_end = sel ? 1'b0 : fe;
    assign ift.cfg_req   = sel ? req : 1'b0;
    assign ift.cfg_word  = word;
    assign ift.cfg_drain = drain;
    assign ift.tx_empty  = sel ? txe : 1'b1;
    assign ift.rx_empty  = sel ? rxe : 1'b1;
    assign ift.frame_end = sel ? fe : 1'b0;

    logic        obs_busy, obs_ack, obs_err, obs_txb, obs_stop, obs_wen;
    logic [31:0] obs_wdata;
    assign obs_busy  = sel ? ift.cfg_busy   : ifa.cfg_busy;
    assign obs_ack   = sel ? ift.cfg_ack    : ifa.cfg_ack;
    assign obs_err   = sel ? ift.cfg_err    : ifa.cfg_err;
    assign obs_txb   = sel ? ift.tx_block   : ifa.tx_block;
    assign obs_stop  = sel ? ift.stop       : ifa.stop;
    assign obs_wen   = sel ? ift.ctrl_wen   : ifa.ctrl_wen;
    assign obs_wdata = sel ? ift.ctrl_wdata : ifa.ctrl_wdata;

    int total = 0;
    int bad = 0;

    int          n_wen, n_stop, first_stop, n_ack, n_err, err_at, n_busy, n_txb, n_overlap;
    int          wen_at[4];
    int          ack_at[4];
    logic [31:0] wdata_at[4];

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_stats();
        n_wen = 0; n_stop = 0; first_stop = -1; n_ack = 0; n_err = 0; err_at = -1;
        n_busy = 0; n_txb = 0; n_overlap = 0;
        for (int j = 0; j < 4; j++) begin
            wen_at[j] = -1; ack_at[j] = -1; wdata_at[j] = '0;
        end
    endtask

    // Cycle i is the cycle that follows the accepting edge by i edges.
    task automatic sample_cycle(input int i);
        if (obs_wen === 1'b1) begin
            if (n_wen < 4) begin
                wen_at[n_wen] = i;
                wdata_at[n_wen] = obs_wdata;
            end
            n_wen++;
        end
        if (obs_stop === 1'b1) begin
            if (first_stop < 0) first_stop = i;
            n_stop++;
        end
        if (obs_ack === 1'b1) begin
            if (n_ack < 4) ack_at[n_ack] = i;
            n_ack++;
        end
        if (obs_err === 1'b1) begin
            if (err_at < 0) err_at = i;
            n_err++;
        end
        if (obs_busy === 1'b1) n_busy++;
        if (obs_txb === 1'b1) n_txb++;
        if ((obs_wen === 1'b1 && obs_ack === 1'b1) || (obs_ack === 1'b1 && obs_err === 1'b1)) n_overlap++;
        if (obs_stop === 1'b1 && obs_busy !== 1'b1) n_overlap++;
    endtask

    task automatic test_reset();
        preset = 1'b0;
        idle(3);
        sel = 1'b0;
        #1;
        total++; if (obs_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", obs_busy); end
        total++; if (obs_txb !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_block: got %b expected 0", obs_txb); end
        total++; if (obs_stop !== 1'b0) begin bad++; $display("[TB] FAIL reset_stop: got %b expected 0", obs_stop); end
        total++; if (obs_wen !== 1'b0) begin bad++; $display("[TB] FAIL reset_wen: got %b expected 0", obs_wen); end
        total++; if (obs_ack !== 1'b0 || obs_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack_err: got %b%b expected 00", obs_ack, obs_err); end
        total++; if (obs_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_wdata: got %h expected 00000000", obs_wdata); end
        sel = 1'b1;
        #1;
        total++; if (obs_wdata !== 32'h0 || obs_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_t_dut: got wdata=%h busy=%b expected 0/0", obs_wdata, obs_busy); end
        sel = 1'b0;
        preset = 1'b1;
        idle(3);
    endtask

    task automatic test_basic_apply();
        sel = 1'b0; word = 32'h0000_0A53; drain = 2'b00; txe = 1'b1; rxe = 1'b1; fe = 1'b0; req = 1'b1;
        clear_stats();
        step();
        for (int i = 0; i < 14; i++) begin
            sample_cycle(i);
            if (i == 0) begin
                total++; if (obs_busy !== 1'b1 || obs_txb !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_rise: got busy=%b tx_block=%b expected 1/1", obs_busy, obs_txb); end
            end
            req = 1'b0;
            fe = (i == 1);
            step();
        end
        total++; if (n_wen !== 1) begin bad++; $display("[TB] FAIL basic_wen_count: got %0d expected 1", n_wen); end
        total++; if (wen_at[0] !== 3) begin bad++; $display("[TB] FAIL basic_wen_cycle: got %0d expected 3", wen_at[0]); end
        total++; if (wdata_at[0] !== 32'h0000_0A53) begin bad++; $display("[TB] FAIL basic_wdata: got %h expected 00000a53", wdata_at[0]); end
        total++; if (n_stop !== 5 || first_stop !== 3) begin bad++; $display("[TB] FAIL basic_stop: got %0d cycles from %0d expected 5 from 3", n_stop, first_stop); end
        total++; if (n_ack !== 1 || ack_at[0] !== 8) begin bad++; $display("[TB] FAIL basic_ack: got %0d at %0d expected 1 at 8", n_ack, ack_at[0]); end
        total++; if (n_err !== 0) begin bad++; $display("[TB] FAIL basic_err: got %0d expected 0", n_err); end
        total++; if (n_busy !== 8) begin bad++; $display("[TB] FAIL basic_busy_len: got %0d expected 8", n_busy); end
        total++; if (n_overlap !== 0) begin bad++; $display("[TB] FAIL basic_exclusive: got %0d expected 0", n_overlap); end
        total++; if (obs_busy !== 1'b0 || obs_wdata !== 32'h0000_0A53) begin bad++; $display("[TB] FAIL basic_after: got busy=%b wdata=%h expected 0/00000a53", obs_busy, obs_wdata); end
    endtask

    task automatic test_tx_drain();
        sel = 1'b0; word = 32'h1234_5678; drain = 2'b01; txe = 1'b0; rxe = 1'b0; fe = 1'b0; req = 1'b1;
        clear_stats();
        step();
        for (int i = 0; i < 40; i++) begin
            sample_cycle(i);
            req = 1'b0;
            txe = (i >= 19);
            fe = ((i % 8) == 3);
            step();
        end
        fe = 1'b0; txe = 1'b1; rxe = 1'b1;
        total++; if (first_stop !== 29) begin bad++; $display("[TB] FAIL drain_stop_start: got %0d expected 29", first_stop); end
        total++; if (n_wen !== 1 || wen_at[0] !== 29) begin bad++; $display("[TB] FAIL drain_wen: got %0d at %0d expected 1 at 29", n_wen, wen_at[0]); end
        total++; if (wdata_at[0] !== 32'h1234_5678) begin bad++; $display("[TB] FAIL drain_wdata: got %h expected 12345678", wdata_at[0]); end
        total++; if (n_txb !== 34) begin bad++; $display("[TB] FAIL drain_tx_block_len: got %0d expected 34", n_txb); end
        total++; if (n_ack !== 1 || ack_at[0] !== 34) begin bad++; $display("[TB] FAIL drain_ack: got %0d at %0d expected 1 at 34", n_ack, ack_at[0]); end
    endtask

    task automatic test_boundary_race();
        sel = 1'b1; word = 32'h0000_5A5A; drain = 2'b00; txe = 1'b1; rxe = 1'b1; fe = 1'b0; req = 1'b1;
        clear_stats();
        step();
        for (int i = 0; i < 30; i++) begin
            sample_cycle(i);
            req = 1'b0;
            fe = (i == 15);
            step();
        end
        fe = 1'b0;
        total++; if (n_err !== 0) begin bad++; $display("[TB] FAIL race_err: got %0d expected 0", n_err); end
        total++; if (n_wen !== 1 || wen_at[0] !== 17) begin bad++; $display("[TB] FAIL race_wen: got %0d at %0d expected 1 at 17", n_wen, wen_at[0]); end
        total++; if (wdata_at[0] !== 32'h0000_5A5A) begin bad++; $display("[TB] FAIL race_wdata: got %h expected 00005a5a", wdata_at[0]); end
        total++; if (n_ack !== 1 || ack_at[0] !== 22) begin bad++; $display("[TB] FAIL race_ack: got %0d at %0d expected 1 at 22", n_ack, ack_at[0]); end
    endtask

    task automatic test_timeout();
        sel = 1'b1; word = 32'hDEAD_BEEF; drain = 2'b10; txe = 1'b1; rxe = 1'b0; fe = 1'b0; req = 1'b1;
        clear_stats();
        step();
        for (int i = 0; i < 25; i++) begin
            sample_cycle(i);
            req = 1'b0;
            fe = ((i % 4) == 0);
            step();
        end
        fe = 1'b0; rxe = 1'b1;
        total++; if (n_err !== 1 || err_at !== 17) begin bad++; $display("[TB] FAIL timeout_err: got %0d at %0d expected 1 at 17", n_err, err_at); end
        total++; if (n_wen !== 0) begin bad++; $display("[TB] FAIL timeout_wen: got %0d expected 0", n_wen); end
        total++; if (n_stop !== 0) begin bad++; $display("[TB] FAIL timeout_stop: got %0d expected 0", n_stop); end
        total++; if (n_ack !== 0) begin bad++; $display("[TB] FAIL timeout_ack: got %0d expected 0", n_ack); end
        total++; if (n_busy !== 17) begin bad++; $display("[TB] FAIL timeout_busy_len: got %0d expected 17", n_busy); end
        total++; if (obs_wdata !== 32'h0000_5A5A) begin bad++; $display("[TB] FAIL timeout_wdata_kept: got %h expected 00005a5a", obs_wdata); end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; word = 32'hAAAA_0001; drain = 2'b00; txe = 1'b1; rxe = 1'b1; fe = 1'b0; req = 1'b1;
        clear_stats();
        step();
        for (int i = 0; i < 60; i++) begin
            sample_cycle(i);
            if (i == 1) word = 32'hBBBB_0002;
            if (i == 26) word = 32'hCCCC_0003;
            req = (i < 38);
            fe = ((i % 16) == 15);
            step();
        end
        req = 1'b0; fe = 1'b0;
        total++; if (n_wen !== 2) begin bad++; $display("[TB] FAIL b2b_wen_count: got %0d expected 2", n_wen); end
        total++; if (wdata_at[0] !== 32'hAAAA_0001 || wen_at[0] !== 17) begin bad++; $display("[TB] FAIL b2b_first: got %h at %0d expected aaaa0001 at 17", wdata_at[0], wen_at[0]); end
        total++; if (wdata_at[1] !== 32'hBBBB_0002 || wen_at[1] !== 33) begin bad++; $display("[TB] FAIL b2b_second: got %h at %0d expected bbbb0002 at 33", wdata_at[1], wen_at[1]); end
        total++; if (n_ack !== 2 || ack_at[0] !== 22 || ack_at[1] !== 38) begin bad++; $display("[TB] FAIL b2b_ack: got %0d at %0d,%0d expected 2 at 22,38", n_ack, ack_at[0], ack_at[1]); end
        total++; if (n_err !== 0 || n_overlap !== 0) begin bad++; $display("[TB] FAIL b2b_exclusive: got err=%0d overlap=%0d expected 0/0", n_err, n_overlap); end
    endtask

    task automatic test_reset_mid_settle();
        sel = 1'b0; word = 32'h0000_0F0F; drain = 2'b00; txe = 1'b1; rxe = 1'b1; fe = 1'b0; req = 1'b1;
        clear_stats();
        step();
        for (int i = 0; i < 14; i++) begin
            sample_cycle(i);
            if (i == 5) begin
                total++; if ({obs_busy, obs_txb, obs_stop, obs_wen, obs_ack, obs_err} !== 6'b0) begin bad++; $display("[TB] FAIL rst_settle_outputs: got %b expected 000000", {obs_busy, obs_txb, obs_stop, obs_wen, obs_ack, obs_err}); end
                total++; if (obs_wdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_settle_wdata: got %h expected 00000000", obs_wdata); end
            end
            req = 1'b0;
            fe = (i == 1);
            preset = (i != 4);
            step();
        end
        preset = 1'b1;
        total++; if (n_ack !== 0) begin bad++; $display("[TB] FAIL rst_settle_ack: got %0d expected 0", n_ack); end
        total++; if (n_stop !== 2) begin bad++; $display("[TB] FAIL rst_settle_stop: got %0d expected 2", n_stop); end

        word = 32'h0000_0C3C; req = 1'b1;
        clear_stats();
        step();
        for (int i = 0; i < 14; i++) begin
            sample_cycle(i);
            req = 1'b0;
            fe = (i == 1);
            step();
        end
        fe = 1'b0;
        total++; if (n_wen !== 1 || wdata_at[0] !== 32'h0000_0C3C) begin bad++; $display("[TB] FAIL rst_after_wen: got %0d data %h expected 1 data 00000c3c", n_wen, wdata_at[0]); end
        total++; if (n_ack !== 1 || ack_at[0] !== 8) begin bad++; $display("[TB] FAIL rst_after_ack: got %0d at %0d expected 1 at 8", n_ack, ack_at[0]); end
    endtask

    initial begin
        sel = 1'b0; req = 1'b0; word = '0; drain = 2'b00; txe = 1'b1; rxe = 1'b1; fe = 1'b0;
        test_reset();
        test_basic_apply();
        idle(4);
        test_tx_drain();
        idle(4);
        test_boundary_race();
        idle(4);
        test_timeout();
        idle(4);
        sel = 1'b0;
        idle(2);
        test_back_to_back();
        idle(4);
        test_reset_mid_settle();
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_cfg_sequencer.md
# i2s_cfg_sequencer

Control-plane sequencer that applies a new 32-bit I2S control word without corrupting a frame in flight. It sits on the pclk side of the I2S transceiver, between the host or APB-facing logic and the control register and FIFO gating. It optionally blocks new Tx writes and waits for the FIFOs to drain, then waits for a frame boundary. It then asserts `stop`, writes the control register, holds `stop` for a settle window, releases it and acknowledges. A timeout aborts the sequence cleanly.

## Interface
- `TIMEOUT`, 1024: maximum pclk cycles spent in DRAIN plus SYNC before abort; ≥2.
- `SETTLE_CYC`, 4: cycles `stop` stays high after the control write; ≥1.
- `pclk` input 1: the single clock for the block.
- `preset` input 1: reset, synchronous, active-low.
- `cfg_req` input 1: level request; sampled only while `cfg_busy`=0.
- `cfg_word` input 32: new control word; latched on acceptance.
- `cfg_drain` input 2: bit0 waits for `tx_empty`, bit1 waits for `rx_empty`; latched on acceptance.
- `tx_empty` input 1: Tx FIFO empty flag.
- `rx_empty` input 1: Rx FIFO empty flag.
- `frame_end` input 1: one-cycle pulse at the ws frame boundary, already synchronised to pclk.
- `cfg_busy` output 1: sequence in progress.
- `cfg_ack` output 1: one-cycle pulse on successful completion.
- `cfg_err` output 1: one-cycle pulse on timeout abort.
- `tx_block` output 1: gates APB writes into the Tx FIFO.
- `stop` output 1: drives the FIFO stop gating (Tx_ren/Rx_wen).
- `ctrl_wen` output 1: one-cycle control register write strobe.
- `ctrl_wdata` output 32: control register write data.

## Operation
- All outputs are registered.
- Reset value of every output is 0, including `ctrl_wdata`. The state returns to IDLE and the counters clear.
- States: IDLE, DRAIN, SYNC, WRITE, SETTLE, DONE, ERR.
- IDLE, when `cfg_req`=1:
  - Latch `cfg_word` and `cfg_drain`.
  - Clear the timeout counter.
  - Go to DRAIN. `cfg_busy`=1 and `tx_block`=1 from the next cycle.
- DRAIN:
  - Leave when (!`cfg_drain`[0] or `tx_empty`) and (!`cfg_drain`[1] or `rx_empty`). Go to SYNC.
  - With `cfg_drain`=00, DRAIN lasts exactly one cycle.
  - `stop` stays 0 so the Tx FIFO can still empty.
- SYNC: wait for `frame_end`=1, then go to WRITE with `stop`=1 from the next cycle.
  - A `frame_end` pulse seen while in DRAIN is not remembered. SYNC requires a fresh pulse.
- WRITE, lasting 1 cycle: `ctrl_wen`=1 and `ctrl_wdata`=latched word. Then go to SETTLE.
- SETTLE: hold `stop`=1 for `SETTLE_CYC` cycles, then go to DONE.
- DONE, lasting 1 cycle:
  - `cfg_ack`=1.
  - `stop`, `tx_block` and `cfg_busy` are 0 in this cycle.
  - Then go to IDLE.
- Timeout:
  - The counter increments every cycle in DRAIN and SYNC. Width is $clog2(TIMEOUT+1).
  - When it reaches TIMEOUT-1 and the exit condition for the current state is false, go to ERR.
- ERR, lasting 1 cycle:
  - `cfg_err`=1 with `stop`, `tx_block` and `cfg_busy` at 0.
  - No `ctrl_wen` is ever issued, and the control register keeps its old value.
  - Then go to IDLE.
- Simultaneous events:
  - If the exit condition and the timeout hit in the same cycle, the exit condition wins.
  - `cfg_req` during DONE or ERR is ignored. A held request is accepted in the following IDLE cycle.
- `ctrl_wdata` holds its last written value after WRITE.
- Reset asserted mid-sequence, including during SETTLE with `stop`=1:
  - At the next edge every output goes to 0.
  - No ack or err is produced.
  - A pending write that has not yet reached WRITE is dropped.

## Timing
- Request accepted at edge k:
  - `cfg_busy`/`tx_block` are high after edge k.
  - The earliest SYNC entry is edge k+1.
- Case `cfg_drain`=00 with `frame_end` high in the cycle after k+1:
  - `stop` rises at k+3.
  - `ctrl_wen` is high during k+3..k+4.
  - SETTLE spans `SETTLE_CYC` cycles.
  - `cfg_ack` pulses `SETTLE_CYC`+1 cycles after `ctrl_wen`.
- Minimum request-to-ack latency is 4+`SETTLE_CYC` cycles.
- Minimum time between accepted requests is 6+`SETTLE_CYC` cycles, because of the IDLE cycle after DONE.
- `stop` is high for exactly 1+`SETTLE_CYC` cycles per successful sequence and never high on abort.
- `ctrl_wen` and `cfg_ack` are never high in the same cycle, and `cfg_ack` and `cfg_err` are mutually exclusive.

## Test plan
- **Basic apply.** Stimulus: `cfg_drain`=00, `cfg_word`=32'h0000_0A53, `frame_end` pulse 3 cycles after request. Required response:
  - exactly one `ctrl_wen` with 32'h0000_0A53;
  - `stop` high for 5 cycles (`SETTLE_CYC`=4);
  - one `cfg_ack`;
  - `cfg_busy` low afterwards.
- **Tx drain.** Stimulus: `cfg_drain`=01, `tx_empty` low for 20 cycles, `frame_end` every 8 cycles. Required response:
  - `tx_block` high throughout;
  - `stop` stays 0 until the first `frame_end` after `tx_empty` rises;
  - the write follows.
- **Timeout.** Stimulus: `TIMEOUT`=16, `cfg_drain`=10, `rx_empty` held 0. Required response:
  - `cfg_err` pulses 17 cycles after acceptance;
  - no `ctrl_wen`;
  - `stop` never asserts;
  - the state returns to IDLE.
- **Boundary race.** Stimulus: `frame_end` arrives in exactly the cycle the counter reaches TIMEOUT-1. Required response: the write proceeds, `cfg_ack` is issued and `cfg_err` is not.
- **Back-to-back and busy.** Stimulus: `cfg_req` held high for 40 cycles with words A then B. Required response:
  - two sequences, with A written first;
  - a change of `cfg_word` while busy does not alter the in-flight write.
- **Reset mid-SETTLE.** Stimulus: deassert `preset` for one cycle during SETTLE. Required response:
  - all outputs are 0 at the next edge;
  - no ack;
  - a new request after reset completes normally.
